// File: rtl/uart_rx_v2_if.sv
// Signal bundle between the uart_rx_v2 receiver (master side) and its line/consumer (slave side).
interface uart_rx_v2_if;
  logic       rx_p;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       rx_busy;

  modport master (input rx_p, output dout, output dout_valid, output frame_err, output rx_busy);
  modport slave  (output rx_p, input dout, input dout_valid, input frame_err, input rx_busy);
endinterface

// File: rtl/uart_rx_v2.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit qualification, mid-bit sampling, stop check.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, decision one cycle later.
module uart_rx_v2 #(
  parameter int clk_freq  = 12000000,
  parameter int uart_freq = 115200
) (
  input  logic         clk,
  input  logic         resetn,
  uart_rx_v2_if.master bus
);

  localparam int BIT_TICKS  = clk_freq / uart_freq;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CNT_W      = $clog2(BIT_TICKS) + 1;

`ifdef UART_RX_MAJORITY_EN
  // Start decision one cycle late; all later decisions inherit the shift.
  localparam int START_LAST = HALF_TICKS;
`else
  localparam int START_LAST = HALF_TICKS - 1;
`endif

  localparam logic [CNT_W-1:0] START_END = CNT_W'(START_LAST);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(BIT_TICKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitpos_q, bitpos_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       sync_q, sync_d;
  logic             rx_s;
  logic             rx_smp;

  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  assign hist_d = {hist_q[0], rx_s};
  assign rx_smp = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hist_q <= 2'b11;
    else         hist_q <= hist_d;
  end
`else
  assign rx_smp = rx_s;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bitpos_d     = bitpos_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    sync_d       = {sync_q[0], bus.rx_p};

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == START_END) begin
          cnt_d    = '0;
          bitpos_d = 3'd0;
          state_d  = rx_smp ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d            = '0;
          shift_d[bitpos_q] = rx_smp;
          if (bitpos_q == 3'd7) state_d  = S_STOP;
          else                  bitpos_d = bitpos_q + 3'd1;
        end
      end
      S_STOP: begin
        // Leaving mid-stop-bit lets a start bit right after a 1-bit stop be caught.
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_smp) begin
            dout_d       = shift_q;
            dout_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bitpos_q     <= 3'd0;
      shift_q      <= 8'h00;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      sync_q       <= 2'b11;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitpos_q     <= bitpos_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      sync_q       <= sync_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.rx_busy    = (state_q != S_IDLE);

endmodule
